// File: rtl/special_register_bank_pkg.sv
// special_register_pkg: shared register indices and default sizing for the special register bank
package special_register_pkg;

    typedef enum logic [2:0] {
        ZERO          = 3'd0,
        ADDRESS       = 3'd1,
        BASE          = 3'd2,
        INDEX         = 3'd3,
        STACK_POINTER = 3'd4,
        BASE_POINTER  = 3'd5,
        DATA          = 3'd6
    } reg_index_e;

    localparam int          DEFAULT_DATA_WIDTH  = 16;
    localparam int          DEFAULT_REG_COUNT   = 8;
    localparam logic [15:0] DEFAULT_STACK_BASE  = 16'hFFFE;
    localparam logic [15:0] DEFAULT_STACK_LIMIT = 16'h8000;
    localparam int          DEFAULT_STACK_STEP  = 2;

endpackage

// File: rtl/special_register_bank_if.sv
// special_register_bank_if: read/write/stack bus between the address unit and the special register bank
interface special_register_bank_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  read;
    logic [ADDR_WIDTH-1:0] readAddress1;
    logic [ADDR_WIDTH-1:0] readAddress2;
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;
    logic                  write;
    logic [ADDR_WIDTH-1:0] writeAddress;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] stackPointer;
    logic                  stackOverflow;
    logic                  stackUnderflow;

    modport master (
        output read, readAddress1, readAddress2, write, writeAddress, writeData, push, pop,
        input  data1, data2, stackPointer, stackOverflow, stackUnderflow
    );

    modport slave (
        input  read, readAddress1, readAddress2, write, writeAddress, writeData, push, pop,
        output data1, data2, stackPointer, stackOverflow, stackUnderflow
    );
endinterface

// File: rtl/special_register_bank_stack_pointer_unit.sv
// stack_pointer_unit: next stack pointer and overflow/underflow events from push/pop requests
module stack_pointer_unit
    import special_register_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] STACK_BASE  = DATA_WIDTH'(DEFAULT_STACK_BASE),
    parameter logic [DATA_WIDTH-1:0] STACK_LIMIT = DATA_WIDTH'(DEFAULT_STACK_LIMIT),
    parameter int                    STACK_STEP  = DEFAULT_STACK_STEP
) (
    input  logic                  push,
    input  logic                  pop,
    input  logic                  override,
    input  logic [DATA_WIDTH-1:0] sp,
    output logic [DATA_WIDTH-1:0] next_sp,
    output logic                  overflow_set,
    output logic                  underflow_set
);
    logic do_push, do_pop;

    // simultaneous push+pop cancel out; an explicit SP write suppresses both
    always_comb begin
        do_push       = push && !pop && !override;
        do_pop        = pop && !push && !override;
        overflow_set  = do_push && sp == STACK_LIMIT;
        underflow_set = do_pop && sp == STACK_BASE;
        next_sp       = (do_push && !overflow_set) ? sp - DATA_WIDTH'(STACK_STEP) :
                        (do_pop && !underflow_set) ? sp + DATA_WIDTH'(STACK_STEP) : sp;
    end
endmodule

// File: rtl/special_register_bank.sv
// special_register_bank: special registers with hardwired zero, bypassed registered reads and a checked stack pointer
module special_register_bank
    import special_register_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int                    REG_COUNT   = DEFAULT_REG_COUNT,
    parameter int                    ADDR_WIDTH  = $clog2(REG_COUNT),
    parameter int                    SP_INDEX    = int'(STACK_POINTER),
    parameter logic [DATA_WIDTH-1:0] STACK_BASE  = DATA_WIDTH'(DEFAULT_STACK_BASE),
    parameter logic [DATA_WIDTH-1:0] STACK_LIMIT = DATA_WIDTH'(DEFAULT_STACK_LIMIT),
    parameter int                    STACK_STEP  = DEFAULT_STACK_STEP
) (
    input logic                    clock,
    input logic                    reset,
    special_register_bank_if.slave bus
);
    logic [DATA_WIDTH-1:0] regs      [REG_COUNT];
    logic [DATA_WIDTH-1:0] next_regs [REG_COUNT];
    logic [DATA_WIDTH-1:0] sp_next;
    logic                  sp_override, overflow_set, underflow_set;

    assign sp_override      = bus.write && bus.writeAddress == ADDR_WIDTH'(SP_INDEX);
    assign bus.stackPointer = regs[SP_INDEX];

    stack_pointer_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .STACK_BASE (STACK_BASE),
        .STACK_LIMIT(STACK_LIMIT),
        .STACK_STEP (STACK_STEP)
    ) u_sp (
        .push         (bus.push),
        .pop          (bus.pop),
        .override     (sp_override),
        .sp           (regs[SP_INDEX]),
        .next_sp      (sp_next),
        .overflow_set (overflow_set),
        .underflow_set(underflow_set)
    );

    // next_regs is the post-edge state; reads sample it, which gives write and push/pop bypass
    always_comb begin
        next_regs = regs;
        if (bus.write && bus.writeAddress != '0) next_regs[bus.writeAddress] = bus.writeData;
        if (!sp_override) next_regs[SP_INDEX] = sp_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= (i == SP_INDEX) ? STACK_BASE : '0;
            bus.data1          <= '0;
            bus.data2          <= '0;
            bus.stackOverflow  <= 1'b0;
            bus.stackUnderflow <= 1'b0;
        end else begin
            regs               <= next_regs;
            bus.data1          <= (bus.read && bus.readAddress1 != '0) ? next_regs[bus.readAddress1] : '0;
            bus.data2          <= (bus.read && bus.readAddress2 != '0) ? next_regs[bus.readAddress2] : '0;
            bus.stackOverflow  <= bus.stackOverflow | overflow_set;
            bus.stackUnderflow <= bus.stackUnderflow | underflow_set;
        end
    end
endmodule

// File: tb/tb_special_register_bank.sv
// tb_special_register_bank: directed vector table, reset corner sequence and randomized run against a reference model
module tb_special_register_bank;
    import special_register_pkg::*;

    typedef struct {
        logic        rst, rd;
        logic [2:0]  ra1, ra2;
        logic        wr;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        psh, pp;
        logic [15:0] d1, d2, sp;
        logic        ovf, unf;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    special_register_bank_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();

    special_register_bank dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic [15:0] m_regs [8];
    logic        m_ovf, m_unf;
    logic [15:0] m_d1, m_d2;

    function automatic vec_t mk(input logic rst, rd, input logic [2:0] ra1, ra2, input logic wr,
                                input logic [2:0] wa, input logic [15:0] wd, input logic psh, pp,
                                input logic [15:0] d1, d2, sp, input logic ovf, unf);
        vec_t v;
        v.rst = rst; v.rd = rd; v.ra1 = ra1; v.ra2 = ra2; v.wr = wr; v.wa = wa; v.wd = wd;
        v.psh = psh; v.pp = pp; v.d1 = d1; v.d2 = d2; v.sp = sp; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, rd, input logic [2:0] ra1, ra2, input logic wr,
                         input logic [2:0] wa, input logic [15:0] wd, input logic psh, pp);
        reset = rst; bus.read = rd; bus.readAddress1 = ra1; bus.readAddress2 = ra2;
        bus.write = wr; bus.writeAddress = wa; bus.writeData = wd; bus.push = psh; bus.pop = pp;
        @(posedge clock);
        #1;
    endtask

    // spec-level reference: apply write, then stack rules, then reads see the new state
    task automatic model_step(input logic rst, rd, input logic [2:0] ra1, ra2, input logic wr,
                              input logic [2:0] wa, input logic [15:0] wd, input logic psh, pp);
        logic [15:0] sp;
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 16'h0;
            m_regs[4] = 16'hFFFE;
            m_ovf = 0; m_unf = 0; m_d1 = 0; m_d2 = 0;
            return;
        end
        sp = m_regs[4];
        if (wr && wa != 0) m_regs[wa] = wd;
        if (!(wr && wa == 4) && psh && !pp) begin
            if (sp == 16'h8000) m_ovf = 1;
            else m_regs[4] = sp - 16'd2;
        end
        if (!(wr && wa == 4) && pp && !psh) begin
            if (sp == 16'hFFFE) m_unf = 1;
            else m_regs[4] = sp + 16'd2;
        end
        m_d1 = (rd && ra1 != 0) ? m_regs[ra1] : 16'h0;
        m_d2 = (rd && ra2 != 0) ? m_regs[ra2] : 16'h0;
    endtask

    initial begin
        vec_t vecs[$];
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //                rst rd ra1 ra2 wr wa wd        psh pp  d1        d2        sp        ovf unf
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hFFFE, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'hFFFE, 16'hFFFE, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h1234, 0, 0, 16'h1234, 16'h0000, 16'hFFFE, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 16'hBEEF, 0, 0, 16'h0000, 16'h1234, 16'hFFFE, 0, 0));
        vecs.push_back(mk(0, 1, 4, 0, 0, 0, 16'h0000, 0, 1, 16'hFFFE, 16'h0000, 16'hFFFE, 0, 1));
        vecs.push_back(mk(0, 1, 4, 0, 0, 0, 16'h0000, 1, 0, 16'hFFFC, 16'h0000, 16'hFFFC, 0, 1));
        vecs.push_back(mk(0, 1, 4, 0, 0, 0, 16'h0000, 1, 0, 16'hFFFA, 16'h0000, 16'hFFFA, 0, 1));
        vecs.push_back(mk(0, 1, 4, 0, 0, 0, 16'h0000, 1, 0, 16'hFFF8, 16'h0000, 16'hFFF8, 0, 1));
        vecs.push_back(mk(0, 1, 4, 0, 1, 4, 16'h8002, 0, 0, 16'h8002, 16'h0000, 16'h8002, 0, 1));
        vecs.push_back(mk(0, 1, 4, 1, 0, 0, 16'h0000, 1, 0, 16'h8000, 16'h1234, 16'h8000, 0, 1));
        vecs.push_back(mk(0, 1, 4, 0, 0, 0, 16'h0000, 1, 0, 16'h8000, 16'h0000, 16'h8000, 1, 1));
        vecs.push_back(mk(0, 1, 4, 0, 0, 0, 16'h0000, 1, 1, 16'h8000, 16'h0000, 16'h8000, 1, 1));
        vecs.push_back(mk(0, 1, 4, 0, 1, 4, 16'h9000, 1, 0, 16'h9000, 16'h0000, 16'h9000, 1, 1));
        vecs.push_back(mk(0, 0, 4, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h9000, 1, 1));
        vecs.push_back(mk(1, 1, 4, 1, 1, 1, 16'h7777, 1, 0, 16'h0000, 16'h0000, 16'hFFFE, 0, 0));
        vecs.push_back(mk(0, 1, 4, 1, 0, 0, 16'h0000, 1, 1, 16'hFFFE, 16'h0000, 16'hFFFE, 0, 0));
        vecs.push_back(mk(0, 1, 4, 0, 1, 4, 16'hFFFE, 0, 1, 16'hFFFE, 16'h0000, 16'hFFFE, 0, 0));
        vecs.push_back(mk(0, 1, 4, 0, 1, 4, 16'h8000, 0, 0, 16'h8000, 16'h0000, 16'h8000, 0, 0));
        vecs.push_back(mk(0, 1, 2, 4, 1, 2, 16'h5555, 1, 0, 16'h5555, 16'h8000, 16'h8000, 1, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rd, vecs[i].ra1, vecs[i].ra2, vecs[i].wr, vecs[i].wa,
                  vecs[i].wd, vecs[i].psh, vecs[i].pp);
            chk($sformatf("vec%0d data1", i), bus.data1, vecs[i].d1);
            chk($sformatf("vec%0d data2", i), bus.data2, vecs[i].d2);
            chk($sformatf("vec%0d sp", i), bus.stackPointer, vecs[i].sp);
            chk($sformatf("vec%0d overflow", i), 16'(bus.stackOverflow), 16'(vecs[i].ovf));
            chk($sformatf("vec%0d underflow", i), 16'(bus.stackUnderflow), 16'(vecs[i].unf));
        end

        // reset arriving alongside a write must drop the write entirely
        drive(0, 0, 0, 0, 1, 3, 16'h1111, 0, 0);
        drive(1, 0, 0, 0, 1, 3, 16'hAAAA, 0, 1);
        drive(0, 1, 3, 4, 0, 0, 16'h0000, 0, 0);
        chk("reset_drops_write", bus.data1, 16'h0000);
        chk("reset_sp", bus.data2, 16'hFFFE);
        chk("reset_underflow", 16'(bus.stackUnderflow), 16'h0000);

        model_step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            logic rst, rd, wr, psh, pp;
            logic [2:0] ra1, ra2, wa;
            logic [15:0] wd;
            rst = ($urandom_range(0, 63) == 0);
            rd  = ($urandom_range(0, 3) != 0);
            ra1 = 3'($urandom_range(0, 7));
            ra2 = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            wr  = ($urandom_range(0, 2) == 0);
            wa  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: wd = 16'h8002;
                1: wd = 16'hFFFC;
                default: wd = 16'($urandom);
            endcase
            psh = ($urandom_range(0, 2) == 0);
            pp  = ($urandom_range(0, 2) == 0);
            model_step(rst, rd, ra1, ra2, wr, wa, wd, psh, pp);
            drive(rst, rd, ra1, ra2, wr, wa, wd, psh, pp);
            chk($sformatf("rnd%0d data1", n), bus.data1, m_d1);
            chk($sformatf("rnd%0d data2", n), bus.data2, m_d2);
            chk($sformatf("rnd%0d sp", n), bus.stackPointer, m_regs[4]);
            chk($sformatf("rnd%0d overflow", n), 16'(bus.stackOverflow), 16'(m_ovf));
            chk($sformatf("rnd%0d underflow", n), 16'(bus.stackUnderflow), 16'(m_unf));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/special_register_bank.md
# special_register_bank

Parametrised special-purpose register bank: the successor to the fixed 8×16 special register file. It keeps a hardwired zero register and provides two registered read ports with write bypass and one write port. It also adds hardware stack-pointer push/pop with bounds checking. It sits beside the general-purpose register file and feeds address/base/index/SP/BP/data operands to the address unit.

## Interface
Parameters:
- DATA_WIDTH, 16, register width in bits
- REG_COUNT, 8, number of registers; power of two, ≥ 8
- ADDR_WIDTH, $clog2(REG_COUNT), index width (derived; do not override)
- SP_INDEX, 4, index of the stack-pointer register
- STACK_BASE, 16'hFFFE, SP value after reset; stack empty
- STACK_LIMIT, 16'h8000, lowest legal SP; stack full
- STACK_STEP, 2, SP change per push/pop

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- read  in  1  read enable for both read ports
- readAddress1  in  ADDR_WIDTH  read port 1 index
- readAddress2  in  ADDR_WIDTH  read port 2 index
- data1  out  DATA_WIDTH  registered read data, port 1
- data2  out  DATA_WIDTH  registered read data, port 2
- write  in  1  write enable
- writeAddress  in  ADDR_WIDTH  write index
- writeData  in  DATA_WIDTH  write value
- push  in  1  SP -= STACK_STEP
- pop  in  1  SP += STACK_STEP
- stackPointer  out  DATA_WIDTH  current SP register value (combinational from storage)
- stackOverflow  out  1  sticky: push attempted at STACK_LIMIT
- stackUnderflow  out  1  sticky: pop attempted at STACK_BASE

## Operation
- Register 0 always reads 0. Writes to index 0 are discarded.
- Write: if write=1 and writeAddress≠0, the register takes writeData at the clock edge.
- Read: if read=1, data1/data2 are loaded at the edge from the addressed registers.
  - Bypass: if write=1 and the addressed index equals writeAddress (≠0), load writeData instead of the stale value.
  - Index 0 loads 0.
  - If read=0, data1/data2 are loaded with 0.
- Stack operations apply only when write=0 or writeAddress≠SP_INDEX. An explicit write to SP overrides push/pop, which are then ignored with no flag set.
  - push only, SP≠STACK_LIMIT: SP ← SP−STACK_STEP.
  - push only, SP=STACK_LIMIT: SP unchanged; stackOverflow ← 1.
  - pop only, SP≠STACK_BASE: SP ← SP+STACK_STEP.
  - pop only, SP=STACK_BASE: SP unchanged; stackUnderflow ← 1.
  - push and pop together: SP unchanged, no flag.
- Read bypass for SP_INDEX covers push/pop: a read of SP in the same cycle returns the updated SP value.
- Arithmetic is modulo 2^DATA_WIDTH. SP values written explicitly outside [STACK_LIMIT, STACK_BASE] are accepted; bounds are checked only by equality.
- Flags clear only on reset.

## Timing
- Read latency 1 cycle: address at edge N, data valid after edge N.
- Write visible to a read issued the same cycle (bypass), and to all later reads.
- stackPointer reflects the register immediately after the edge.
- Reset (synchronous, dominant over all other inputs):
  - all registers ← 0, except SP ← STACK_BASE
  - data1, data2 ← 0
  - stackOverflow, stackUnderflow ← 0
  - stackPointer = STACK_BASE
- Reset asserted mid-sequence discards that cycle's write/push/pop.

## Structure
- Shared package special_register_pkg holds:
  - register index constants: ZERO=0, ADDRESS=1, BASE=2, INDEX=3, STACK_POINTER=4, BASE_POINTER=5, DATA=6
  - default DATA_WIDTH / STACK_* constants
- One sub-module is natural: stack_pointer_unit. It computes next SP and the flag sets from push, pop, current SP and the write-override condition. The bank instantiates it for SP_INDEX.

## Test plan
- Reset, then read indexes 0 and 4 → data1=0, data2=16'hFFFE; flags 0.
- Write 16'h1234 to index 1 with read of index 1 the same cycle → data1=16'h1234 after that edge. Write 16'hBEEF to index 0 → reads 0.
- From reset, pop → SP stays 16'hFFFE, stackUnderflow=1. Push ×3 → SP=16'hFFF8; stackUnderflow still 1.
- Write SP=16'h8002, push → 16'h8000; push again → SP 16'h8000, stackOverflow=1.
- push=pop=1 → SP unchanged, no flags. Write SP=16'h9000 with push=1 → SP=16'h9000, push ignored.
- read=0 → data1=data2=0 next cycle. Assert reset during push → SP=STACK_BASE, flags 0.
